nv_ram_rwsthp_param: RTL
========================

Name: nv_ram_rwsthp_param

Overview:
- Parametrised 1-read/1-write synchronous RAM model with a registered read address, a bypass mux and an output register.
- Successor to the fixed-size rwsthp models; one module covers any depth and width.
- Adds features the fixed models lack: asynchronous reset, write-to-read forwarding, per-entry written tracking, an output valid flag and sticky out-of-range error flags.
- Used as the FPGA/behavioural model behind datapath buffers.

Parameters:
DEPTH, 60, number of entries (2..4096)
WIDTH, 168, data width in bits (1..1024)
AW, 6, address width; must satisfy 2**AW >= DEPTH
FWD_EN, 1, 1 = a write to the address being output-read in the same cycle forwards di to dout_r
ZERO_UNWRITTEN, 1, 1 = reading an entry not written since reset returns all-zero

Ports:
clk  input  1  clock; all state updates on posedge
rst  input  1  asynchronous, active-high reset
ra  input  AW  read address
re  input  1  read enable; latches ra into ra_d
ore  input  1  output register enable
dout  output  WIDTH  registered read data
dout_vld  output  1  dout_r holds data captured by at least one ore since reset
wa  input  AW  write address
we  input  1  write enable
di  input  WIDTH  write data
byp_sel  input  1  1 = output stage captures dbyp instead of RAM data
dbyp  input  WIDTH  bypass data
err_oob  output  2  sticky flags: bit0 = write address >= DEPTH, bit1 = read address >= DEPTH
pwrbus_ram_pd  input  32  power bus; ignored by the model

Behaviour:
- Reset (rst=1, asynchronous): ra_d=0, rd_oob_d=0, dout_r=0, dout_vld=0, err_oob=0, written[DEPTH-1:0]=0. Array contents are not reset.
- Write, cycle N with we=1:
  - If wa<DEPTH: M[wa]<=di and written[wa]<=1 at the edge.
  - If wa>=DEPTH: no array update; err_oob[0]<=1.
- Read address stage, re=1:
  - ra_d<=ra.
  - rd_oob_d<=(ra>=DEPTH); if ra>=DEPTH, err_oob[1]<=1.
  - re=0: ra_d and rd_oob_d hold.
- Array read (combinational from ra_d), ram_q:
  - 0 if rd_oob_d.
  - Otherwise 0 if ZERO_UNWRITTEN and !written[ra_d].
  - Otherwise M[ra_d].
- Forwarding: if FWD_EN and we and wa==ra_d and wa<DEPTH and !rd_oob_d, then ram_q=di; this overrides the unwritten check. If FWD_EN=0, ram_q shows the pre-write contents.
- Output stage:
  - ore=1: dout_r<=(byp_sel ? dbyp : ram_q); dout_vld<=1.
  - ore=0: dout_r and dout_vld hold.
- Latency: re at edge N and ore at edge N+1 gives dout valid after edge N+1, i.e. 2 cycles from ra to dout.
- Same-edge re and ore: ore captures data from the old ra_d; the new ra_d takes effect the following cycle.
- byp_sel bypasses forwarding and error gating; it does not set err_oob.
- err_oob bits stay set until rst; both bits may set in the same cycle.
- rst asserted mid-operation: an in-flight write at that edge is not guaranteed to land. Outputs are 0 while rst is high. The first read after release of an address not rewritten returns 0 when ZERO_UNWRITTEN=1.
- Simultaneous we and re to the same address: the write lands at edge N, and ra_d points to it from N+1, so the read returns new data with no forwarding needed.
- DEPTH not a power of two: addresses DEPTH..2**AW-1 are out of range; they never alias.

Test Plan:
- Defaults (DEPTH=60, WIDTH=168): write 0xA5..A5 to addr 7, then re ra=7, then ore next cycle -> dout=0xA5..A5, dout_vld=1, 2-cycle latency.
- After reset, re ra=12 (never written), then ore -> dout=0, dout_vld=1; with ZERO_UNWRITTEN=0 -> dout=X/prior contents (check not gated).
- ra_d=20 holding 0x11..; same cycle we wa=20 di=0x22.. with ore=1 -> FWD_EN=1: dout=0x22..; FWD_EN=0: dout=0x11..; next ore -> 0x22.. in both cases.
- byp_sel=1, dbyp=0x3C.., ore=1 while ra_d is out of range -> dout=0x3C.., err_oob[1] set only by the earlier re.
- we wa=62 -> array unchanged (readback of addrs 0..59 matches the scoreboard), err_oob=2'b01; then re ra=63 -> err_oob=2'b11, next ore dout=0.
- Assert rst asynchronously mid-cycle while dout=0xFF.. -> dout=0, dout_vld=0, err_oob=0 immediately, without waiting for a clock edge; re-read of addr 7 returns 0 until rewritten. Repeat with DEPTH=5, WIDTH=8, AW=3 for the parametrisation check.

Source files
------------

// File: rtl/nv_ram_rwsthp_param.sv
// nv_ram_rwsthp_param: parametrised 1R/1W synchronous RAM model with a
// registered read address, a write-to-read forwarding path, a bypass mux
// and an output register.
// Also tracks which entries have been written since reset and keeps
// sticky out-of-range error flags.
module nv_ram_rwsthp_param #(
    parameter int DEPTH          = 60,
    parameter int WIDTH          = 168,
    parameter int AW             = 6,
    parameter bit FWD_EN         = 1'b1,
    parameter bit ZERO_UNWRITTEN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [AW-1:0]    ra,
    input  logic             re,
    input  logic             ore,
    output logic [WIDTH-1:0] dout,
    output logic             dout_vld,
    input  logic [AW-1:0]    wa,
    input  logic             we,
    input  logic [WIDTH-1:0] di,
    input  logic             byp_sel,
    input  logic [WIDTH-1:0] dbyp,
    output logic [1:0]       err_oob,
    input  logic [31:0]      pwrbus_ram_pd
);

    // Index width of the storage array. An address is range-checked on the
    // full AW bits before it is used, so the truncated index never aliases.
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] DEPTH_A = DEPTH[AW:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [DEPTH-1:0] written;
    logic [AW-1:0]    ra_d;
    logic             rd_oob_d;
    logic [WIDTH-1:0] dout_r;
    logic             dout_vld_r;
    logic [1:0]       err_r;
    logic [WIDTH-1:0] ram_q;

    logic             wa_ok;
    logic             ra_ok;
    logic [IW-1:0]    wa_idx;
    logic [IW-1:0]    ra_idx;
    logic             fwd_hit;

    // The power bus exists only for interface compatibility.
    logic unused_pwr;
    assign unused_pwr = ^pwrbus_ram_pd;

    assign wa_ok  = ({1'b0, wa} < DEPTH_A);
    assign ra_ok  = ({1'b0, ra} < DEPTH_A);
    assign wa_idx = wa[IW-1:0];
    assign ra_idx = ra_d[IW-1:0];

    // A write landing on the entry currently addressed by the read stage.
    assign fwd_hit = FWD_EN && we && wa_ok && !rd_oob_d && (wa == ra_d);

    // Storage array: in-range writes only, contents are never reset.
    always_ff @(posedge clk) begin
        if (we && wa_ok) begin
            mem[wa_idx] <= di;
        end
    end

    // Per-entry "written since reset" flags backing the zero-unwritten read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            written <= '0;
        end else if (we && wa_ok) begin
            written[wa_idx] <= 1'b1;
        end
    end

    // Read address stage: capture the address and its range check together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ra_d     <= '0;
            rd_oob_d <= 1'b0;
        end else if (re) begin
            ra_d     <= ra;
            rd_oob_d <= !ra_ok;
        end
    end

    // Array read data: forwarding wins, then range gating, then the
    // unwritten gating, then the stored word.
    always_comb begin
        ram_q = '0;
        if (fwd_hit) begin
            ram_q = di;
        end else if (rd_oob_d) begin
            ram_q = '0;
        end else if (ZERO_UNWRITTEN && !written[ra_idx]) begin
            ram_q = '0;
        end else begin
            ram_q = mem[ra_idx];
        end
    end

    // Output register: bypass data or array data, plus the valid flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout_r     <= '0;
            dout_vld_r <= 1'b0;
        end else if (ore) begin
            dout_r     <= byp_sel ? dbyp : ram_q;
            dout_vld_r <= 1'b1;
        end
    end

    // Sticky range errors: bit0 for writes, bit1 for read address captures.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_r <= 2'b00;
        end else begin
            if (we && !wa_ok) begin
                err_r[0] <= 1'b1;
            end
            if (re && !ra_ok) begin
                err_r[1] <= 1'b1;
            end
        end
    end

    assign dout     = dout_r;
    assign dout_vld = dout_vld_r;
    assign err_oob  = err_r;

endmodule
